// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one unified memory between the core and a debug/loader port.
// One access in flight at a time; reads wait out the memory's fixed latency before acking.
module mem_port_arbiter #(
    parameter int AW      = 32,
    parameter int DW      = 32,
    parameter int MEM_LAT = 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          cpu_req,
    input  logic          cpu_we,
    input  logic [AW-1:0] cpu_addr,
    input  logic [DW-1:0] cpu_wdata,
    output logic          cpu_ack,
    output logic [DW-1:0] cpu_rdata,
    input  logic          dbg_req,
    input  logic          dbg_we,
    input  logic [AW-1:0] dbg_addr,
    input  logic [DW-1:0] dbg_wdata,
    output logic          dbg_ack,
    output logic [DW-1:0] dbg_rdata,
    input  logic          dbg_lock,
    output logic          mem_en,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    output logic          busy
);

    localparam int CW = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
    localparam logic [CW-1:0] LAT_M1 = CW'(MEM_LAT - 1);

    typedef enum logic [1:0] {IDLE, ACCESS, WAIT, RESP} state_t;
    typedef enum logic {OWN_CPU, OWN_DBG} owner_t;

    state_t        state_q, state_d;
    owner_t        owner_q, last_q, grant_owner;
    logic          grant_valid;
    logic          cpu_eligible;
    logic          we_q;
    logic [AW-1:0] addr_q;
    logic [DW-1:0] wdata_q;
    logic [CW-1:0] cnt_q;
    logic [DW-1:0] cpu_rdata_q, dbg_rdata_q;
    logic          capture;

    // NOTE: every variable gets a default before the case so no path leaves it unassigned (no latches).
    always_comb begin
        cpu_eligible = cpu_req & ~dbg_lock;
        grant_valid  = cpu_eligible | dbg_req;
        grant_owner  = dbg_req ? OWN_DBG : OWN_CPU;
        if (cpu_eligible && dbg_req) begin
            grant_owner = (last_q == OWN_CPU) ? OWN_DBG : OWN_CPU;
        end

        state_d = state_q;
        case (state_q)
            IDLE:    if (grant_valid) state_d = ACCESS;
            ACCESS:  state_d = we_q ? RESP : WAIT;
            WAIT:    if (cnt_q == '0) state_d = RESP;
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Reads always pass through WAIT for MEM_LAT cycles, so the last WAIT cycle is ACCESS+MEM_LAT.
    assign capture = (state_q == WAIT) && (cnt_q == '0);

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    // NOTE: the data registers are reset too, because they drive outputs that must read 0 after reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            owner_q     <= OWN_CPU;
            last_q      <= OWN_DBG;
            we_q        <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            cnt_q       <= '0;
            cpu_rdata_q <= '0;
            dbg_rdata_q <= '0;
        end else begin
            state_q <= state_d;

            if (state_q == IDLE && grant_valid) begin
                owner_q <= grant_owner;
                last_q  <= grant_owner;
                we_q    <= (grant_owner == OWN_DBG) ? dbg_we    : cpu_we;
                addr_q  <= (grant_owner == OWN_DBG) ? dbg_addr  : cpu_addr;
                wdata_q <= (grant_owner == OWN_DBG) ? dbg_wdata : cpu_wdata;
            end

            if (state_q == ACCESS) begin
                cnt_q <= LAT_M1;
            end else if (state_q == WAIT && cnt_q != '0) begin
                cnt_q <= cnt_q - CW'(1);
            end

            if (capture) begin
                if (owner_q == OWN_DBG) dbg_rdata_q <= mem_rdata;
                else                    cpu_rdata_q <= mem_rdata;
            end
        end
    end

    assign mem_en    = (state_q == ACCESS);
    assign mem_we    = mem_en & we_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign busy      = (state_q != IDLE);
    assign cpu_ack   = (state_q == RESP) && (owner_q == OWN_CPU);
    assign dbg_ack   = (state_q == RESP) && (owner_q == OWN_DBG);
    assign cpu_rdata = cpu_rdata_q;
    assign dbg_rdata = dbg_rdata_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: two instances (MEM_LAT=2 and MEM_LAT=4), a memory responder,
// a transaction-timeline model checked every cycle, and directed scenarios with literal expectations.
module tb_mem_port_arbiter;

    localparam int AW = 32;
    localparam int DW = 32;

    function automatic int lat(input int i);
        return (i == 0) ? 2 : 4;
    endfunction

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          reset     [2];
    logic          cpu_req   [2], cpu_we [2], dbg_req [2], dbg_we [2], dbg_lock [2];
    logic [AW-1:0] cpu_addr  [2], dbg_addr [2], mem_addr [2];
    logic [DW-1:0] cpu_wdata [2], dbg_wdata [2], mem_wdata [2], mem_rdata [2];
    logic [DW-1:0] cpu_rdata [2], dbg_rdata [2];
    logic          cpu_ack   [2], dbg_ack [2], mem_en [2], mem_we [2], busy [2];

    for (genvar g = 0; g < 2; g++) begin : g_dut
        mem_port_arbiter #(.AW(AW), .DW(DW), .MEM_LAT(g == 0 ? 2 : 4)) u_dut (
            .clk       (clk),
            .reset     (reset[g]),
            .cpu_req   (cpu_req[g]),
            .cpu_we    (cpu_we[g]),
            .cpu_addr  (cpu_addr[g]),
            .cpu_wdata (cpu_wdata[g]),
            .cpu_ack   (cpu_ack[g]),
            .cpu_rdata (cpu_rdata[g]),
            .dbg_req   (dbg_req[g]),
            .dbg_we    (dbg_we[g]),
            .dbg_addr  (dbg_addr[g]),
            .dbg_wdata (dbg_wdata[g]),
            .dbg_ack   (dbg_ack[g]),
            .dbg_rdata (dbg_rdata[g]),
            .dbg_lock  (dbg_lock[g]),
            .mem_en    (mem_en[g]),
            .mem_we    (mem_we[g]),
            .mem_addr  (mem_addr[g]),
            .mem_wdata (mem_wdata[g]),
            .mem_rdata (mem_rdata[g]),
            .busy      (busy[g])
        );
    end

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Memory responder: writes land at the mem_en cycle, read data shows up MEM_LAT cycles later
    // and junk is driven on every other cycle so a mistimed capture is visible.
    int            cyc = 0;
    logic [DW-1:0] mem     [2][256];
    int            due     [2];
    logic [DW-1:0] due_val [2];

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (mem_en[i] === 1'b1) begin
                if (mem_we[i] === 1'b1) begin
                    mem[i][mem_addr[i][7:0]] = mem_wdata[i];
                end else begin
                    due[i]     = cyc + lat(i);
                    due_val[i] = mem[i][mem_addr[i][7:0]];
                end
            end
            mem_rdata[i] = (cyc == due[i]) ? due_val[i] : (32'hBAD0_0000 | DW'(cyc));
        end
    end

    // Reference model: an access granted in idle cycle t occupies cycles t+1..t+end, where
    // end = 2 for writes and 2+MEM_LAT for reads; mem_en at offset 1, ack at offset end.
    bit            m_seen [2];
    bit            m_act  [2];
    int            m_k    [2];
    bit            m_own  [2];
    bit            m_last [2];
    bit            m_we   [2];
    logic [AW-1:0] m_addr [2];
    logic [DW-1:0] m_wd   [2];
    logic [DW-1:0] m_rd   [2][2];

    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            automatic int    last_k = m_we[i] ? 2 : 2 + lat(i);
            automatic bit    at_ack = m_act[i] && (m_k[i] == last_k);
            automatic string p      = $sformatf("L%0d", lat(i));
            automatic bit    ce, de;
            if (m_seen[i]) begin
                check({p, " busy"},      busy[i],      m_act[i]);
                check({p, " mem_en"},    mem_en[i],    m_act[i] && m_k[i] == 1);
                check({p, " mem_we"},    mem_we[i],    m_act[i] && m_k[i] == 1 && m_we[i]);
                check({p, " mem_addr"},  mem_addr[i],  m_addr[i]);
                check({p, " mem_wdata"}, mem_wdata[i], m_wd[i]);
                check({p, " cpu_ack"},   cpu_ack[i],   at_ack && !m_own[i]);
                check({p, " dbg_ack"},   dbg_ack[i],   at_ack && m_own[i]);
                check({p, " cpu_rdata"}, cpu_rdata[i], m_rd[i][0]);
                check({p, " dbg_rdata"}, dbg_rdata[i], m_rd[i][1]);
            end
            if (reset[i]) begin
                m_seen[i] = 1'b1;
                m_act[i]  = 1'b0;
                m_last[i] = 1'b1;
                m_addr[i] = '0;
                m_wd[i]   = '0;
                m_rd[i][0] = '0;
                m_rd[i][1] = '0;
            end else if (m_act[i]) begin
                if (!m_we[i] && m_k[i] == last_k - 1) m_rd[i][m_own[i]] = mem[i][m_addr[i][7:0]];
                if (at_ack) m_act[i] = 1'b0;
                else        m_k[i]++;
            end else begin
                ce = cpu_req[i] && !dbg_lock[i];
                de = dbg_req[i];
                if (ce || de) begin
                    m_own[i]  = (ce && de) ? !m_last[i] : de;
                    m_last[i] = m_own[i];
                    m_act[i]  = 1'b1;
                    m_k[i]    = 1;
                    m_we[i]   = m_own[i] ? dbg_we[i]    : cpu_we[i];
                    m_addr[i] = m_own[i] ? dbg_addr[i]  : cpu_addr[i];
                    m_wd[i]   = m_own[i] ? dbg_wdata[i] : cpu_wdata[i];
                end
            end
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_ack(input int i, input string name, input bit exp_dbg, input int exp_cyc);
        automatic bit found = 1'b0;
        automatic int c     = 0;
        while (!found && c < 40) begin
            step(1);
            c++;
            if (cpu_ack[i] === 1'b1 || dbg_ack[i] === 1'b1) found = 1'b1;
        end
        check({name, " ack seen"}, found, 1'b1);
        if (found) begin
            check({name, " winner"}, dbg_ack[i], exp_dbg);
            check({name, " ack cycle"}, c, exp_cyc);
        end
    endtask

    task automatic wait_en(input int i, input string name, input int exp_cyc);
        automatic bit found = 1'b0;
        automatic int c     = 0;
        while (!found && c < 40) begin
            step(1);
            c++;
            if (mem_en[i] === 1'b1) found = 1'b1;
        end
        check({name, " mem_en seen"}, found, 1'b1);
        if (found) check({name, " mem_en spacing"}, c, exp_cyc);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 2; i++) begin
            for (int j = 0; j < 256; j++) mem[i][j] = {16'(i), 16'(j)} ^ 32'h5A5A_0000;
            reset[i] = 1'b1;  cpu_req[i] = 1'b0; cpu_we[i] = 1'b0; dbg_req[i] = 1'b0;
            dbg_we[i] = 1'b0; dbg_lock[i] = 1'b0; cpu_addr[i] = '0; dbg_addr[i] = '0;
            cpu_wdata[i] = '0; dbg_wdata[i] = '0; mem_rdata[i] = '0; due[i] = -1;
        end
        mem[0][8'h10] = 32'hDEAD_BEEF;
        mem[1][8'h40] = 32'h4040_5555;
        mem[1][8'h44] = 32'h4444_AAAA;
        step(3);
        reset[0] = 1'b0;
        reset[1] = 1'b0;
        step(1);
        check("reset busy", busy[0], 1'b0);
        check("reset mem_addr", mem_addr[0], 32'h0);
        check("reset cpu_rdata", cpu_rdata[0], 32'h0);

        // Single CPU read, MEM_LAT=2.
        cpu_req[0] = 1'b1; cpu_we[0] = 1'b0; cpu_addr[0] = 32'h10;
        step(1);
        check("rd c1 mem_en", mem_en[0], 1'b1);
        check("rd c1 mem_we", mem_we[0], 1'b0);
        check("rd c1 mem_addr", mem_addr[0], 32'h10);
        step(3);
        check("rd c4 cpu_ack", cpu_ack[0], 1'b1);
        check("rd c4 cpu_rdata", cpu_rdata[0], 32'hDEAD_BEEF);
        check("rd c4 busy", busy[0], 1'b1);
        step(1);
        cpu_req[0] = 1'b0;
        check("rd c5 busy", busy[0], 1'b0);
        step(2);

        // Single CPU write.
        cpu_req[0] = 1'b1; cpu_we[0] = 1'b1; cpu_addr[0] = 32'h20; cpu_wdata[0] = 32'h1234;
        step(1);
        check("wr c1 mem_en", mem_en[0], 1'b1);
        check("wr c1 mem_we", mem_we[0], 1'b1);
        check("wr c1 mem_addr", mem_addr[0], 32'h20);
        check("wr c1 mem_wdata", mem_wdata[0], 32'h1234);
        step(1);
        check("wr c2 cpu_ack", cpu_ack[0], 1'b1);
        check("wr c2 dbg_ack", dbg_ack[0], 1'b0);
        step(1);
        cpu_req[0] = 1'b0;
        step(2);

        // Round robin after reset with both requests held: CPU, DBG, CPU, DBG.
        reset[0] = 1'b1;
        step(1);
        reset[0] = 1'b0;
        cpu_req[0] = 1'b1; cpu_we[0] = 1'b1; cpu_addr[0] = 32'h30; cpu_wdata[0] = 32'hC0C0;
        dbg_req[0] = 1'b1; dbg_we[0] = 1'b1; dbg_addr[0] = 32'h34; dbg_wdata[0] = 32'hD0D0;
        wait_ack(0, "rr1", 1'b0, 2);
        wait_ack(0, "rr2", 1'b1, 3);
        wait_ack(0, "rr3", 1'b0, 3);
        wait_ack(0, "rr4", 1'b1, 3);
        cpu_req[0] = 1'b0; dbg_req[0] = 1'b0;
        step(3);

        // dbg_lock: debug served three times, then CPU once lock and dbg_req drop.
        dbg_lock[0] = 1'b1; cpu_req[0] = 1'b1; dbg_req[0] = 1'b1;
        wait_ack(0, "lock1", 1'b1, 2);
        wait_ack(0, "lock2", 1'b1, 3);
        wait_ack(0, "lock3", 1'b1, 3);
        dbg_lock[0] = 1'b0; dbg_req[0] = 1'b0;
        wait_ack(0, "unlock", 1'b0, 3);
        cpu_req[0] = 1'b0;
        step(3);

        // Lock rising mid CPU access lets it finish, then blocks a held cpu_req.
        cpu_req[0] = 1'b1;
        step(1);
        dbg_lock[0] = 1'b1;
        wait_ack(0, "lockmid", 1'b0, 1);
        step(4);
        check("locked busy", busy[0], 1'b0);
        dbg_lock[0] = 1'b0;
        wait_ack(0, "relock", 1'b0, 2);
        cpu_req[0] = 1'b0;
        step(3);

        // MEM_LAT=4: debug read, then reset during WAIT drops a CPU read.
        dbg_req[1] = 1'b1; dbg_we[1] = 1'b0; dbg_addr[1] = 32'h44; dbg_wdata[1] = 32'h77;
        wait_ack(1, "L4 dbg rd", 1'b1, 6);
        check("L4 dbg_rdata", dbg_rdata[1], 32'h4444_AAAA);
        step(1);
        dbg_req[1] = 1'b0;
        step(2);
        cpu_req[1] = 1'b1; cpu_we[1] = 1'b0; cpu_addr[1] = 32'h40; cpu_wdata[1] = 32'h99;
        step(3);
        check("L4 in wait busy", busy[1], 1'b1);
        reset[1] = 1'b1;
        step(1);
        reset[1] = 1'b0;
        check("rst mem_en", mem_en[1], 1'b0);
        check("rst mem_addr", mem_addr[1], 32'h0);
        check("rst mem_wdata", mem_wdata[1], 32'h0);
        check("rst cpu_ack", cpu_ack[1], 1'b0);
        check("rst dbg_rdata", dbg_rdata[1], 32'h0);
        check("rst busy", busy[1], 1'b0);
        dbg_req[1] = 1'b1;
        wait_ack(1, "post rst", 1'b0, 6);
        check("post rst cpu_rdata", cpu_rdata[1], 32'h4040_5555);
        cpu_req[1] = 1'b0;
        wait_ack(1, "post rst dbg", 1'b1, 7);
        dbg_req[1] = 1'b0;
        step(3);

        // Back-to-back throughput with cpu_req held.
        cpu_req[0] = 1'b1; cpu_we[0] = 1'b1; cpu_addr[0] = 32'h50; cpu_wdata[0] = 32'hABCD;
        wait_en(0, "wr first", 1);
        wait_en(0, "wr b2b", 3);
        cpu_req[0] = 1'b0;
        step(4);
        cpu_req[0] = 1'b1; cpu_we[0] = 1'b0; cpu_addr[0] = 32'h10;
        wait_en(0, "rd first", 1);
        wait_en(0, "rd b2b", 5);
        cpu_req[0] = 1'b0;
        step(8);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
